// File: rtl/cpu_mem_responder_if.sv
// Purpose: CPU memory bus plus boot-loader byte stream, as seen by cpu_mem_responder.
// Latency: none (signal bundle only).
// Backpressure: loader side uses ld_valid/ld_ready; the CPU side has no stall.
// Ports: adr_bus/rd_mem/wr_mem/data_bus_in from the CPU, data_bus_out to the CPU,
//        ld_valid/ld_data/ld_last from the loader, ld_ready to it, cpu_run and
//        bus_err as status. "slave" is the responder's view, "master" the driver's.
interface cpu_mem_responder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] adr_bus;
    logic              rd_mem;
    logic              wr_mem;
    logic [DATA_W-1:0] data_bus_in;
    logic [DATA_W-1:0] data_bus_out;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              cpu_run;
    logic              bus_err;

    modport slave (
        input  adr_bus, rd_mem, wr_mem, data_bus_in,
        input  ld_valid, ld_data, ld_last,
        output data_bus_out, ld_ready, cpu_run, bus_err
    );

    modport master (
        output adr_bus, rd_mem, wr_mem, data_bus_in,
        output ld_valid, ld_data, ld_last,
        input  data_bus_out, ld_ready, cpu_run, bus_err
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Purpose: program/data RAM behind the accumulator CPU, boot-loaded before the CPU is released.
// Latency: CPU read data one cycle after the rd_mem edge; writes land at the wr_mem edge.
// Backpressure: ld_ready is high only while loading; the CPU bus is never stalled.
// Ports: clk, reset (async active-low); bus (slave modport): CPU address/strobes/data,
//        loader valid/ready/data/last, cpu_run (CPU out of reset), bus_err (sticky
//        simultaneous rd_mem+wr_mem). LOAD_MAX must lie in 1..2**ADDR_W.
module cpu_mem_responder #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int LOAD_MAX = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_mem_responder_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    // Pointer value of the final byte the loader may send before a forced exit.
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(LOAD_MAX - 1);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] dout_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;

    // Next state, load pointer and the single RAM write port, shared between
    // the loader (LOAD) and CPU writes (RUN).
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        bus_err_d = bus_err_q;
        mem_we    = 1'b0;
        mem_waddr = bus.adr_bus;
        mem_wdata = bus.data_bus_in;
        rd_en     = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // ld_ready is constant-high here, so ld_valid alone marks a transfer.
                if (bus.ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q[ADDR_W-1:0];
                    mem_wdata = bus.ld_data;
                    ptr_d     = ptr_q + PTR_ONE;
                    if (bus.ld_last || (ptr_q == LAST_PTR)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                case ({bus.rd_mem, bus.wr_mem})
                    2'b10:   rd_en     = 1'b1;
                    2'b01:   mem_we    = 1'b1;
                    // Conflicting strobes: no access at all, just flag it.
                    2'b11:   bus_err_d = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end

    // RAM is deliberately outside the reset domain: contents survive reset so a
    // partial load is simply overwritten by the next one.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_LOAD;
            ptr_q     <= '0;
            bus_err_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            bus_err_q <= bus_err_d;
            if (rd_en) begin
                dout_q <= mem[bus.adr_bus];
            end
        end
    end

    // Both status outputs decode the single-bit state flop directly, so they
    // are glitch-free and change only at a clock edge or reset.
    assign bus.ld_ready     = (state_q == ST_LOAD);
    assign bus.cpu_run      = (state_q == ST_RUN);
    assign bus.bus_err      = bus_err_q;
    assign bus.data_bus_out = dout_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Purpose: scoreboard bench for cpu_mem_responder against a byte-array reference model.
// Latency: expectations are queued at stimulus time and checked 1 ns after the next edge.
// Backpressure: loader stimulus ignores ld_ready; the model decides what is accepted.
module tb_cpu_mem_responder;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int LOAD_MAX = 64;
    localparam int DEPTH    = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    cpu_mem_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOAD_MAX (LOAD_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit [7:0] dout;
        bit       dout_known;
        bit       ld_ready;
        bit       cpu_run;
        bit       bus_err;
        string    tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference model: RAM as a byte array, loader progress as a byte count.
    bit [7:0] m_mem   [DEPTH];
    bit       m_known [DEPTH];
    bit       m_running;
    int       m_count;
    bit       m_err;
    bit [7:0] m_dout;
    bit       m_dout_known;

    task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_running    = 1'b0;
        m_count      = 0;
        m_err        = 1'b0;
        m_dout       = 8'h00;
        m_dout_known = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model by one edge, queue expectations.
    task automatic step(string tag, bit v, bit [7:0] d, bit last,
                        bit rd, bit wr, bit [5:0] adr, bit [7:0] din);
        exp_t e;
        @(negedge clk);
        bus.ld_valid    = v;
        bus.ld_data     = d;
        bus.ld_last     = last;
        bus.rd_mem      = rd;
        bus.wr_mem      = wr;
        bus.adr_bus     = adr;
        bus.data_bus_in = din;
        if (!m_running) begin
            if (v) begin
                m_mem[m_count]   = d;
                m_known[m_count] = 1'b1;
                m_count++;
                if (last || m_count == LOAD_MAX) m_running = 1'b1;
            end
        end else if (rd && wr) begin
            m_err = 1'b1;
        end else if (rd) begin
            m_dout       = m_mem[adr];
            m_dout_known = m_known[adr];
        end else if (wr) begin
            m_mem[adr]   = din;
            m_known[adr] = 1'b1;
        end
        e.dout       = m_dout;
        e.dout_known = m_dout_known;
        e.ld_ready   = !m_running;
        e.cpu_run    = m_running;
        e.bus_err    = m_err;
        e.tag        = tag;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = 8'h00;
        bus.ld_last     = 1'b0;
        bus.rd_mem      = 1'b0;
        bus.wr_mem      = 1'b0;
        bus.adr_bus     = 6'd0;
        bus.data_bus_in = 8'h00;
        #2;
        chk1("rst_ld_ready", bus.ld_ready, 1'b1);
        chk1("rst_cpu_run", bus.cpu_run, 1'b0);
        chk1("rst_bus_err", bus.bus_err, 1'b0);
        chk8("rst_data_bus_out", bus.data_bus_out, 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: the DUT presents a new output set after every edge; compare it
    // against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk1({mon_e.tag, ":ld_ready"}, bus.ld_ready, mon_e.ld_ready);
            chk1({mon_e.tag, ":cpu_run"}, bus.cpu_run, mon_e.cpu_run);
            chk1({mon_e.tag, ":bus_err"}, bus.bus_err, mon_e.bus_err);
            if (mon_e.dout_known)
                chk8({mon_e.tag, ":data_bus_out"}, bus.data_bus_out, mon_e.dout);
        end
    end

    int       op;
    bit [5:0] ra;
    bit [7:0] rd8;
    bit [7:0] gap_bytes [10];
    int       sent;
    bit       v;

    initial begin
        reset           = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = 8'h00;
        bus.ld_last     = 1'b0;
        bus.rd_mem      = 1'b0;
        bus.wr_mem      = 1'b0;
        bus.adr_bus     = 6'd0;
        bus.data_bus_in = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 8'h00;
            m_known[i] = 1'b0;
        end
        model_reset();

        // Short load terminated by ld_last.
        do_reset();
        step("t1_b0", 1, 8'h11, 0, 0, 0, 0, 0);
        step("t1_b1", 1, 8'h22, 0, 0, 0, 0, 0);
        step("t1_b2", 1, 8'h33, 1, 0, 0, 0, 0);
        step("t1_extra", 1, 8'h44, 0, 0, 0, 0, 0);

        // RUN: read, write, read-after-write, conflicting strobes.
        step("rd2", 0, 0, 0, 1, 0, 6'd2, 0);
        step("wr2", 0, 0, 0, 0, 1, 6'd2, 8'hA5);
        step("rd2_new", 0, 0, 0, 1, 0, 6'd2, 0);
        step("rdwr1", 0, 0, 0, 1, 1, 6'd1, 8'hFF);
        step("idle", 0, 0, 0, 0, 0, 6'd0, 0);
        step("rd1", 0, 0, 0, 1, 0, 6'd1, 0);
        step("rd0", 0, 0, 0, 1, 0, 6'd0, 0);

        // Random RUN traffic over a small address window.
        for (int i = 0; i < 150; i++) begin
            op  = int'($urandom_range(0, 9));
            ra  = 6'($urandom_range(0, 7));
            rd8 = 8'($urandom);
            step("rnd_run", 0, 0, 0, (op < 4) || (op == 9),
                 ((op >= 4) && (op < 8)) || (op == 9), ra, rd8);
        end

        // Full-depth load with no ld_last; a 65th byte must be refused.
        do_reset();
        for (int i = 0; i < LOAD_MAX; i++)
            step("t2_load", 1, 8'(i), 0, 0, 0, 0, 0);
        step("t2_65th", 1, 8'hEE, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            step("t2_rd", 0, 0, 0, 1, 0, 6'(i), 0);

        // Gappy load with CPU strobes that must be ignored during LOAD.
        do_reset();
        for (int i = 0; i < 10; i++) gap_bytes[i] = 8'($urandom);
        sent = 0;
        while (sent < 10) begin
            v   = 1'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 3));
            ra  = 6'($urandom_range(0, 15));
            rd8 = 8'($urandom);
            step("t5_load", v, gap_bytes[sent], v && (sent == 9),
                 op[0], op[1], ra, rd8);
            if (v) sent++;
        end
        for (int i = 0; i < 16; i++)
            step("t5_rd", 0, 0, 0, 1, 0, 6'(i), 0);

        // Reset mid-load, then a one-byte reload.
        do_reset();
        step("t6_b0", 1, 8'hC1, 0, 0, 0, 0, 0);
        step("t6_b1", 1, 8'hC2, 0, 0, 0, 0, 0);
        do_reset();
        step("t6_reload", 1, 8'h7E, 1, 0, 0, 0, 0);
        step("t6_rd0", 0, 0, 0, 1, 0, 6'd0, 0);
        step("t6_rd1", 0, 0, 0, 1, 0, 6'd1, 0);
        step("t6_rd2", 0, 0, 0, 1, 0, 6'd2, 0);
        step("t6_idle", 0, 0, 0, 0, 0, 6'd0, 0);

        repeat (3) @(negedge clk);
        chk8("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
